aer_core_event_dispatcher: RTL
==============================

AER_CORE_EVENT_DISPATCHER -- requirements
Module: aer_core_event_dispatcher

Interface
REQ-001 SHALL have parameter CORE_W, default 4, meaning core grid width.
REQ-002 SHALL have parameter CORE_H, default 4, meaning core grid height.
REQ-003 SHALL have parameter CORE_NUM, default 16, meaning populated cores, CORE_NUM <= CORE_W*CORE_H.
REQ-004 SHALL have parameter AER_IN_WIDTH, default 12, meaning upstream address width = AER_IN_CORE_WIDTH + $clog2(CORE_H) + $clog2(CORE_W).
REQ-005 SHALL have parameter AER_IN_CORE_WIDTH, default 8, meaning core-side address width {type[1:0], id}.
REQ-006 SHALL have port clk, input, 1, meaning the single clock.
REQ-007 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-008 SHALL have port aer_in_req, input, 1, meaning upstream four-phase request.
REQ-009 SHALL have port aer_in_addr, input, AER_IN_WIDTH, meaning {type, id, core_h, core_w}, stable while aer_in_req is high.
REQ-010 SHALL have port aer_in_ack, output, 1, meaning upstream four-phase acknowledge.
REQ-011 SHALL have port core_req, output, CORE_NUM, meaning per-core request.
REQ-012 SHALL have port core_addr, output, AER_IN_CORE_WIDTH, meaning shared core-side address {type, id}.
REQ-013 SHALL have port core_ack, input, CORE_NUM, meaning per-core four-phase acknowledge.
REQ-014 SHALL have port busy, output, 1, meaning state != IDLE.
REQ-015 SHALL have port drop_cnt, output, 8, meaning saturating count of dropped events.

Function
REQ-016 SHALL decode type = addr[MSB:MSB-1]: 2'b00 neuron, 2'b01 timestep; 2'b10/2'b11 invalid.
REQ-017 SHALL compute target index = core_h*CORE_W + core_w; an index >= CORE_NUM on a neuron event is invalid.
REQ-018 SHALL implement FSM states IDLE, DISPATCH, RELEASE, UP_ACK, all transitions on the clk rising edge.
REQ-019 SHALL, in IDLE with aer_in_req=1, register core_addr and target_mask at that edge: neuron -> one-hot(index); timestep -> all CORE_NUM bits.
REQ-020 SHALL, on a valid event at that same edge, drive core_req=target_mask and enter DISPATCH, so core_req rises 1 cycle after aer_in_req is sampled.
REQ-021 SHALL, on an invalid event, leave core_req at 0, increment drop_cnt (saturating at 255) and enter UP_ACK.
REQ-022 SHALL, in DISPATCH, OR (core_ack & target_mask) into a sticky ack_mask every cycle.
REQ-023 SHALL, when (ack_mask | (core_ack & target_mask)) == target_mask, clear all core_req at that edge and enter RELEASE; for timestep, all cores' reqs fall together.
REQ-024 SHALL, in RELEASE, when (core_ack & target_mask) == 0, set aer_in_ack=1 and enter UP_ACK.
REQ-025 SHALL, in UP_ACK, when aer_in_req == 0, clear aer_in_ack, clear ack_mask and enter IDLE; a new event is accepted no earlier than the following cycle.
REQ-026 SHALL ignore aer_in_req and aer_in_addr changes outside IDLE.
REQ-027 SHALL ignore core_ack bits outside target_mask in every state.
REQ-028 SHALL hold core_addr constant from DISPATCH entry until IDLE re-entry.
REQ-029 SHALL have no timeout: a core that never acks holds the FSM in DISPATCH.

Reset
REQ-030 SHALL, on rst=1 at any time including mid-transfer, immediately force state=IDLE, core_req=0, core_addr=0, aer_in_ack=0, busy=0, ack_mask=0 and drop_cnt=0.
REQ-031 SHALL accept a new event on the first edge after rst deasserts when aer_in_req=1.

Verification
REQ-032 SHALL cover a neuron event: aer_in_addr=12'h056 -> core_req=16'h0040 and core_addr=8'h05; core 6 acks then releases -> aer_in_ack rises; req drops -> ack drops.
REQ-033 SHALL cover a timestep event: aer_in_addr=12'h400 with core acks staggered over 1-16 cycles -> all 16 core_req held until the last ack, then fall together, and aer_in_ack only after all acks are low.
REQ-034 SHALL cover an invalid type: aer_in_addr=12'h800 -> core_req stays 0, aer_in_ack handshake completes, drop_cnt=1; after 300 such events drop_cnt=255.
REQ-035 SHALL cover out of range with CORE_NUM=12: core_h=3, core_w=0 -> dropped, drop_cnt increments.
REQ-036 SHALL cover a spurious ack: core 3 acks during a neuron event to core 6 -> no effect on progress.
REQ-037 SHALL cover mid-transfer reset: rst asserted in DISPATCH -> all outputs 0 in the same cycle; the next event after reset completes normally.

Source files
------------

// File: rtl/aer_core_event_dispatcher_if.sv
// AER dispatcher bus: upstream four-phase request/ack plus the per-core fan-out.
// The dispatcher takes the slave view; the upstream sender and cores take the master view.
interface aer_core_event_dispatcher_if #(
  parameter int CORE_NUM          = 16,
  parameter int AER_IN_WIDTH      = 12,
  parameter int AER_IN_CORE_WIDTH = 8
);
  logic                         aer_in_req;
  logic [AER_IN_WIDTH-1:0]      aer_in_addr;
  logic                         aer_in_ack;
  logic [CORE_NUM-1:0]          core_req;
  logic [AER_IN_CORE_WIDTH-1:0] core_addr;
  logic [CORE_NUM-1:0]          core_ack;

  modport master (
    output aer_in_req, aer_in_addr, core_ack,
    input  aer_in_ack, core_req, core_addr
  );

  modport slave (
    input  aer_in_req, aer_in_addr, core_ack,
    output aer_in_ack, core_req, core_addr
  );
endinterface

// File: rtl/aer_core_event_dispatcher.sv
// Routes one upstream AER event at a time to a single core (neuron) or to all cores
// (timestep), completing four-phase handshakes on both sides; invalid events are counted.
module aer_core_event_dispatcher #(
  parameter int CORE_W            = 4,
  parameter int CORE_H            = 4,
  parameter int CORE_NUM          = 16,
  parameter int AER_IN_WIDTH      = 12,
  parameter int AER_IN_CORE_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  aer_core_event_dispatcher_if.slave       bus,
  output logic                             busy,
  output logic [7:0]                       drop_cnt
);

  localparam int HW = $clog2(CORE_H);
  localparam int WW = $clog2(CORE_W);

  typedef enum logic [1:0] {IDLE, DISPATCH, RELEASE, UP_ACK} state_t;

  state_t state, state_nxt;

  logic [1:0]          ev_type;
  logic [HW-1:0]       ev_h;
  logic [WW-1:0]       ev_w;
  int unsigned         ev_idx;
  logic [CORE_NUM-1:0] ev_mask;
  logic                ev_valid;

  logic [CORE_NUM-1:0] target_mask;
  logic [CORE_NUM-1:0] ack_mask;
  logic [CORE_NUM-1:0] acked;
  logic                all_acked;
  logic                any_ack;

  logic accept, drop, req_clr, ack_set, ack_clr;

  assign ev_type = bus.aer_in_addr[AER_IN_WIDTH-1 -: 2];
  assign ev_w    = bus.aer_in_addr[WW-1:0];
  assign ev_h    = bus.aer_in_addr[WW +: HW];
  assign ev_idx  = 32'(ev_h) * 32'(CORE_W) + 32'(ev_w);

  always_comb begin
    ev_mask  = '0;
    ev_valid = 1'b0;
    case (ev_type)
      2'b00: begin
        ev_valid = (ev_idx < 32'(CORE_NUM));
        for (int unsigned i = 0; i < CORE_NUM; i++) ev_mask[i] = (ev_idx == i);
      end
      2'b01: begin
        ev_valid = 1'b1;
        ev_mask  = '1;
      end
      default: ;
    endcase
  end

  // Acks from cores outside the current target are masked everywhere.
  assign acked     = ack_mask | (bus.core_ack & target_mask);
  assign all_acked = (acked == target_mask);
  assign any_ack   = |(bus.core_ack & target_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.aer_in_req) state_nxt = ev_valid ? DISPATCH : UP_ACK;
      DISPATCH: if (all_acked)      state_nxt = RELEASE;
      RELEASE:  if (!any_ack)       state_nxt = UP_ACK;
      UP_ACK:   if (!bus.aer_in_req) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept  = (state == IDLE) && bus.aer_in_req;
    drop    = accept && !ev_valid;
    req_clr = (state == DISPATCH) && all_acked;
    ack_set = drop || ((state == RELEASE) && !any_ack);
    ack_clr = (state == UP_ACK) && !bus.aer_in_req;
    busy    = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.core_req   <= '0;
      bus.core_addr  <= '0;
      bus.aer_in_ack <= 1'b0;
      target_mask    <= '0;
      ack_mask       <= '0;
      drop_cnt       <= '0;
    end else begin
      if (accept) begin
        bus.core_addr <= bus.aer_in_addr[AER_IN_WIDTH-1 -: AER_IN_CORE_WIDTH];
        target_mask   <= ev_valid ? ev_mask : '0;
        bus.core_req  <= ev_valid ? ev_mask : '0;
      end
      if (req_clr) bus.core_req <= '0;
      if (state == DISPATCH) ack_mask <= acked;
      if (ack_set) begin
        bus.aer_in_ack <= 1'b1;
      end else if (ack_clr) begin
        bus.aer_in_ack <= 1'b0;
        ack_mask       <= '0;
      end
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
